data_enumerator_v2: RTL and testbench

- Next-generation element enumerator for ndata streams.
- Attaches a per-element serial tag to every lane of an NUM_ELEMENTS-wide beat.
- Adds over the previous enumerator:
  - keep-aware dense numbering mode
  - runtime start offset and stride
  - wrap detection
  - registered output stage (timing break)
- Sits between a stream source and downstream tagged consumers (sorters, joins, scatter units).

---
 rtl/data_enumerator_v2_if.sv | 33 +++
 rtl/data_enumerator_v2.sv | 157 +++++++++++++++
 tb/tb_data_enumerator_v2.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_enumerator_v2_if.sv
// Stream bundle for data_enumerator_v2: upstream beat channel, downstream
// tagged beat channel and the per-stream tag configuration.
// master = the surrounding logic (source + sink), slave = the enumerator.
interface data_enumerator_v2_if #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SERIAL_WIDTH = 32
);
  logic [SERIAL_WIDTH-1:0]              cfg_base;
  logic [SERIAL_WIDTH-1:0]              cfg_stride;
  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   in_data;
  logic [NUM_ELEMENTS-1:0]              in_keep;
  logic                                 in_last;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   out_data;
  logic [NUM_ELEMENTS-1:0]              out_keep;
  logic [NUM_ELEMENTS*SERIAL_WIDTH-1:0] out_tag;
  logic                                 out_last;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_wrap;

  modport master (
    output cfg_base, cfg_stride, in_data, in_keep, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_keep, out_tag, out_last, out_valid, out_wrap
  );

  modport slave (
    input  cfg_base, cfg_stride, in_data, in_keep, in_last, in_valid, out_ready,
    output in_ready, out_data, out_keep, out_tag, out_last, out_valid, out_wrap
  );
endinterface

// File: rtl/data_enumerator_v2.sv
// data_enumerator_v2: attaches a serial tag to every lane of a beat.
// Tags start at cfg_base (sampled on the first beat of a stream) and step by
// cfg_stride per element, either per lane position (DENSE=0) or per kept lane
// (DENSE=1). out_wrap flags a stream whose tag arithmetic overflowed.
// One registered output stage, full throughput.
// Optional statistics counters: define DATA_ENUMERATOR_STATS_EN.
module data_enumerator_v2 #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SERIAL_WIDTH = 32,
  parameter int DENSE        = 0
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DATA_ENUMERATOR_STATS_EN
  output logic [31:0] stat_streams,
  output logic [31:0] stat_elements,
`endif
  data_enumerator_v2_if.slave bus
);

  // CW holds any element count 0..NUM_ELEMENTS; WW holds the untruncated
  // base + count*stride so overflow past the tag width is visible.
  localparam int CW = $clog2(NUM_ELEMENTS) + 1;
  localparam int WW = SERIAL_WIDTH + CW;

  typedef enum logic {SOS, MID} state_t;

  state_t                  state_reg, state_next;
  logic [SERIAL_WIDTH-1:0] counter_reg, counter_next;
  logic [SERIAL_WIDTH-1:0] stride_reg, stride_next;
  logic                    wrap_reg, wrap_next;

  logic                    in_fire;
  logic [SERIAL_WIDTH-1:0] beat_base;
  logic [SERIAL_WIDTH-1:0] beat_stride;
  logic [CW-1:0]           prefix [0:NUM_ELEMENTS];
  logic [CW-1:0]           adv_cnt;
  logic [WW-1:0]           beat_sum;
  logic [NUM_ELEMENTS-1:0] lane_wrap;
  logic                    beat_wrap;
  logic                    wrap_out;
  logic [NUM_ELEMENTS*SERIAL_WIDTH-1:0] tag_next;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // First beat of a stream takes its numbering from the config inputs;
  // later beats continue from the running counter and latched stride.
  assign beat_base   = (state_reg == SOS) ? bus.cfg_base   : counter_reg;
  assign beat_stride = (state_reg == SOS) ? bus.cfg_stride : stride_reg;

  // prefix[i] = number of kept lanes below lane i.
  assign prefix[0] = '0;

  generate
    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_lane
      logic [CW-1:0] lane_idx;
      logic          lane_on;
      logic [WW-1:0] lane_sum;

      assign prefix[gi+1] = prefix[gi] + CW'(bus.in_keep[gi]);
      assign lane_idx     = (DENSE != 0) ? prefix[gi] : CW'(gi);
      assign lane_on      = (DENSE == 0) || bus.in_keep[gi];
      assign lane_sum     = WW'(beat_base) + WW'(lane_idx) * WW'(beat_stride);
      assign tag_next[gi*SERIAL_WIDTH +: SERIAL_WIDTH] =
        lane_on ? lane_sum[SERIAL_WIDTH-1:0] : '0;
      assign lane_wrap[gi] = lane_on && (lane_sum[WW-1:SERIAL_WIDTH] != '0);
    end
  endgenerate

  // Dense mode advances only by the kept lanes; positional mode by the width.
  assign adv_cnt   = (DENSE != 0) ? prefix[NUM_ELEMENTS] : CW'(NUM_ELEMENTS);
  assign beat_sum  = WW'(beat_base) + WW'(adv_cnt) * WW'(beat_stride);
  assign beat_wrap = (beat_sum[WW-1:SERIAL_WIDTH] != '0) || (|lane_wrap);
  assign wrap_out  = ((state_reg == MID) && wrap_reg) || beat_wrap;

  // Stream state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SOS;
      counter_reg <= '0;
      stride_reg  <= '0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      stride_reg  <= stride_next;
      wrap_reg    <= wrap_next;
    end
  end

  // Next-state logic: a last beat always returns to SOS with a clean counter.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    stride_next  = stride_reg;
    wrap_next    = wrap_reg;
    unique case (state_reg)
      SOS: if (in_fire && !bus.in_last) state_next = MID;
      MID: if (in_fire && bus.in_last)  state_next = SOS;
      default: state_next = SOS;
    endcase
    if (in_fire) begin
      stride_next = beat_stride;
      if (bus.in_last) begin
        counter_next = '0;
        wrap_next    = 1'b0;
      end else begin
        counter_next = beat_sum[SERIAL_WIDTH-1:0];
        wrap_next    = wrap_out;
      end
    end
  end

  // Output stage: load on input handshake, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
      bus.out_tag   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_wrap  <= 1'b0;
    end else if (in_fire) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data;
      bus.out_keep  <= bus.in_keep;
      bus.out_tag   <= tag_next;
      bus.out_last  <= bus.in_last;
      bus.out_wrap  <= wrap_out;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef DATA_ENUMERATOR_STATS_EN
  logic [32:0] streams_sum;
  logic [32:0] elements_sum;

  assign streams_sum  = {1'b0, stat_streams} + 33'd1;
  assign elements_sum = {1'b0, stat_elements} + 33'(prefix[NUM_ELEMENTS]);

  // Saturating stream / kept-element counters, updated on input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_streams  <= '0;
      stat_elements <= '0;
    end else if (in_fire) begin
      if (bus.in_last)
        stat_streams <= streams_sum[32] ? '1 : streams_sum[31:0];
      stat_elements <= elements_sum[32] ? '1 : elements_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_data_enumerator_v2.sv
// Testbench for data_enumerator_v2: one positional and one dense instance
// (4 lanes, 8-bit tags so wraps are frequent) driven by the same stimulus and
// checked against an integer-arithmetic reference model.
module tb_data_enumerator_v2;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 8;

  typedef struct packed {
    logic [N*DW-1:0] data;
    logic [N-1:0]    keep;
    logic [N*SW-1:0] tag;
    logic            last;
    logic            wrap;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_enumerator_v2_if #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW)) if0();
  data_enumerator_v2_if #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW)) if1();

`ifdef DATA_ENUMERATOR_STATS_EN
  logic [31:0] st_streams0, st_elements0, st_streams1, st_elements1;
`endif

  data_enumerator_v2 #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW), .DENSE(0)) dut0 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DATA_ENUMERATOR_STATS_EN
    .stat_streams(st_streams0),
    .stat_elements(st_elements0),
`endif
    .bus(if0)
  );

  data_enumerator_v2 #(.NUM_ELEMENTS(N), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW), .DENSE(1)) dut1 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DATA_ENUMERATOR_STATS_EN
    .stat_streams(st_streams1),
    .stat_elements(st_elements1),
`endif
    .bus(if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = positional, 1 = dense.
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  bit    m_mid[2];
  int    m_cnt[2];
  int    m_stride[2];
  bit    m_wrap[2];
  int    m_streams[2];
  int    m_elems[2];

  // Current stimulus.
  logic          cur_valid;
  logic [N-1:0]  cur_keep;
  logic [N*DW-1:0] cur_data;
  logic          cur_last;
  logic [SW-1:0] cur_base;
  logic [SW-1:0] cur_stride;
  logic          cur_ready;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic beat_t q_front(input int d);
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  // Reference: tags are base + k*stride computed as plain integers, where k
  // is the lane position (positional) or the count of kept lanes before it
  // (dense). Any true value above 255 marks the stream as wrapped.
  task automatic model_accept(input int d);
    int    base, stride, k, t, adv;
    bit    w;
    beat_t b;
    if (!m_mid[d]) begin
      base   = int'(cur_base);
      stride = int'(cur_stride);
      m_stride[d] = stride;
      w = 1'b0;
    end else begin
      base   = m_cnt[d];
      stride = m_stride[d];
      w = m_wrap[d];
    end
    b.data = cur_data;
    b.keep = cur_keep;
    b.last = cur_last;
    b.tag  = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (d == 0) begin
        t = base + i * stride;
      end else if (cur_keep[i]) begin
        t = base + k * stride;
        k++;
      end else begin
        t = -1;
      end
      if (t >= 0) begin
        b.tag[i*SW +: SW] = SW'(t % 256);
        if (t > 255) w = 1'b1;
      end
    end
    adv = ((d == 0) ? N : k) * stride;
    if (base + adv > 255) w = 1'b1;
    b.wrap = w;
    m_elems[d] += $countones(cur_keep);
    if (cur_last) begin
      m_streams[d]++;
      m_mid[d]  = 1'b0;
      m_cnt[d]  = 0;
      m_wrap[d] = 1'b0;
    end else begin
      m_mid[d]  = 1'b1;
      m_cnt[d]  = (base + adv) % 256;
      m_wrap[d] = w;
    end
    if (d == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_mid[d] = 1'b0;
      m_cnt[d] = 0;
      m_stride[d] = 0;
      m_wrap[d] = 1'b0;
      m_streams[d] = 0;
      m_elems[d] = 0;
    end
  endtask

  // Compare one instance's outputs with the model for the current cycle.
  task automatic step_dut(input int d, input logic ir, input logic ov,
                          input logic [N*DW-1:0] od, input logic [N-1:0] ok,
                          input logic [N*SW-1:0] ot, input logic ol, input logic ow);
    beat_t e;
    check_value($sformatf("d%0d_in_ready", d), 64'(ir), 64'((q_size(d) == 0) || cur_ready));
    check_value($sformatf("d%0d_out_valid", d), 64'(ov), 64'(q_size(d) != 0));
    if (ov && q_size(d) != 0) begin
      e = q_front(d);
      check_value($sformatf("d%0d_out_data", d), 64'(od), 64'(e.data));
      check_value($sformatf("d%0d_out_keep", d), 64'(ok), 64'(e.keep));
      check_value($sformatf("d%0d_out_tag", d), 64'(ot), 64'(e.tag));
      check_value($sformatf("d%0d_out_last", d), 64'(ol), 64'(e.last));
      check_value($sformatf("d%0d_out_wrap", d), 64'(ow), 64'(e.wrap));
      if (cur_ready) begin
        $display("d%0d beat tag=%h keep=%b last=%0b wrap=%0b", d, ot, ok, ol, ow);
        q_pop(d);
      end
    end
    if (cur_valid && ir) model_accept(d);
  endtask

  task automatic drive();
    if0.in_valid = cur_valid;  if1.in_valid = cur_valid;
    if0.in_keep  = cur_keep;   if1.in_keep  = cur_keep;
    if0.in_data  = cur_data;   if1.in_data  = cur_data;
    if0.in_last  = cur_last;   if1.in_last  = cur_last;
    if0.cfg_base = cur_base;   if1.cfg_base = cur_base;
    if0.cfg_stride = cur_stride; if1.cfg_stride = cur_stride;
    if0.out_ready = cur_ready; if1.out_ready = cur_ready;
  endtask

  task automatic run_cycle(input logic v, input logic [N-1:0] k, input logic l,
                           input logic [SW-1:0] b, input logic [SW-1:0] s, input logic r);
    @(negedge clk);
    cur_valid = v;
    cur_keep  = k;
    cur_data  = {$urandom, $urandom};
    cur_last  = l;
    cur_base  = b;
    cur_stride = s;
    cur_ready = r;
    drive();
    #1;
    step_dut(0, if0.in_ready, if0.out_valid, if0.out_data, if0.out_keep, if0.out_tag, if0.out_last, if0.out_wrap);
    step_dut(1, if1.in_ready, if1.out_valid, if1.out_data, if1.out_keep, if1.out_tag, if1.out_last, if1.out_wrap);
  endtask

  // Asynchronous reset while a beat is held on the output.
  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("rst_mid_d0_out_valid", 64'(if0.out_valid), 64'd0);
    check_value("rst_mid_d1_out_valid", 64'(if1.out_valid), 64'd0);
    check_value("rst_mid_d0_out_tag", 64'(if0.out_tag), 64'd0);
    check_value("rst_mid_d1_out_wrap", 64'(if1.out_wrap), 64'd0);
    model_reset();
    cur_valid = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic rst_done;
    logic [SW-1:0] rs;
    rst_done = 1'b0;
    model_reset();
    cur_valid = 1'b0; cur_keep = '0; cur_data = '0; cur_last = 1'b0;
    cur_base = '0; cur_stride = '0; cur_ready = 1'b1;
    drive();
    #2 rst_n = 1'b0;
    #1;
    check_value("reset_out_valid", 64'(if0.out_valid), 64'd0);
    check_value("reset_out_wrap", 64'(if0.out_wrap), 64'd0);
    check_value("reset_out_last", 64'(if0.out_last), 64'd0);
    check_value("reset_out_data", 64'(if0.out_data), 64'd0);
    check_value("reset_out_keep", 64'(if0.out_keep), 64'd0);
    check_value("reset_out_tag", 64'(if1.out_tag), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap across two beats, cfg changes mid-stream ignored, then clean restart.
    run_cycle(1, 4'hF, 0, 8'd250, 8'd1, 1);
    run_cycle(1, 4'hF, 1, 8'd7,   8'd3, 1);
    run_cycle(1, 4'hF, 1, 8'd0,   8'd1, 1);
    // Dense numbering with sparse keep, then restart at base 0.
    run_cycle(1, 4'b1011, 0, 8'd100, 8'd2, 1);
    run_cycle(1, 4'b0110, 1, 8'd9,   8'd9, 1);
    run_cycle(1, 4'b0000, 0, 8'd0,   8'd1, 1);
    run_cycle(1, 4'hF,    1, 8'd5,   8'd5, 1);
    // Backpressure for three cycles mid-stream.
    run_cycle(1, 4'hF, 0, 8'd10, 8'd1, 1);
    repeat (3) run_cycle(1, 4'hF, 0, 8'd0, 8'd0, 0);
    run_cycle(1, 4'hF, 1, 8'd0, 8'd0, 1);
    run_cycle(0, 4'h0, 0, 8'd0, 8'd0, 1);

    // Randomized traffic.
    for (int c = 0; c < 1200; c++) begin
      if (!rst_done && c >= 600 && exp_q0.size() != 0) begin
        mid_reset();
        rst_done = 1'b1;
      end
      rs = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      run_cycle(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), rs,
                ($urandom_range(0, 3) != 0));
    end
    repeat (3) run_cycle(0, 4'h0, 0, 8'd0, 8'd0, 1);
    check_value("rst_mid_seen", 64'(rst_done), 64'd1);
    check_value("drained_d0", 64'(exp_q0.size()), 64'd0);
    check_value("drained_d1", 64'(exp_q1.size()), 64'd0);
`ifdef DATA_ENUMERATOR_STATS_EN
    check_value("stat_streams_d0", 64'(st_streams0), 64'(m_streams[0]));
    check_value("stat_elements_d0", 64'(st_elements0), 64'(m_elems[0]));
    check_value("stat_streams_d1", 64'(st_streams1), 64'(m_streams[1]));
    check_value("stat_elements_d1", 64'(st_elements1), 64'(m_elems[1]));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
